// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection
// and flush; one held instruction, 1-cycle latency, full throughput.
module id_ex_stage #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   in_opcode,
    input  logic [N-1:0] in_imm,
    input  logic [2:0]   in_rd_addr,
    input  logic         in_rd_we,
    input  logic         in_is_load,
    input  logic [2:0]   in_rs1_addr,
    input  logic [2:0]   in_rs2_addr,
    input  logic         in_use_rs1,
    input  logic         in_use_rs2,
    input  logic [N-1:0] rf_read_data1,
    input  logic [N-1:0] rf_read_data2,
    input  logic         ex_fwd_we,
    input  logic [2:0]   ex_fwd_addr,
    input  logic [N-1:0] ex_fwd_data,
    input  logic         mem_fwd_we,
    input  logic [2:0]   mem_fwd_addr,
    input  logic [N-1:0] mem_fwd_data,
    input  logic         wb_fwd_we,
    input  logic [2:0]   wb_fwd_addr,
    input  logic [N-1:0] wb_fwd_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   out_opcode,
    output logic [N-1:0] out_op1,
    output logic [N-1:0] out_op2,
    output logic [N-1:0] out_imm,
    output logic [2:0]   out_rd_addr,
    output logic         out_rd_we,
    output logic         out_is_load,
    output logic [15:0]  stall_count
);

    localparam int unsigned SCW = 16;
    localparam logic [SCW-1:0] STALL_MAX = '1;

    logic         accept_c;
    logic         hazard_c;
    logic [N-1:0] op1_c;
    logic [N-1:0] op2_c;

    // Youngest producer wins; register file is the fallback.
    function automatic logic [N-1:0] resolve(
        input logic         use_rs,
        input logic [2:0]   addr,
        input logic [N-1:0] rf_data,
        input logic         ex_we,
        input logic [2:0]   ex_addr,
        input logic [N-1:0] ex_data,
        input logic         mem_we,
        input logic [2:0]   mem_addr,
        input logic [N-1:0] mem_data,
        input logic         wb_we,
        input logic [2:0]   wb_addr,
        input logic [N-1:0] wb_data
    );
        logic [N-1:0] r;
        r = rf_data;
        if (use_rs) begin
            if (ex_we && ex_addr == addr)        r = ex_data;
            else if (mem_we && mem_addr == addr) r = mem_data;
            else if (wb_we && wb_addr == addr)   r = wb_data;
        end
        return r;
    endfunction

    always_comb begin
        accept_c = !out_valid || out_ready;
        hazard_c = in_valid && out_valid && out_is_load && out_rd_we &&
                   ((in_use_rs1 && in_rs1_addr == out_rd_addr) ||
                    (in_use_rs2 && in_rs2_addr == out_rd_addr));
        op1_c = resolve(in_use_rs1, in_rs1_addr, rf_read_data1,
                        ex_fwd_we, ex_fwd_addr, ex_fwd_data,
                        mem_fwd_we, mem_fwd_addr, mem_fwd_data,
                        wb_fwd_we, wb_fwd_addr, wb_fwd_data);
        op2_c = resolve(in_use_rs2, in_rs2_addr, rf_read_data2,
                        ex_fwd_we, ex_fwd_addr, ex_fwd_data,
                        mem_fwd_we, mem_fwd_addr, mem_fwd_data,
                        wb_fwd_we, wb_fwd_addr, wb_fwd_data);
    end

    assign in_ready = flush || (accept_c && !hazard_c);

    // Pipeline register; any empty slot forces the control bits low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_imm     <= '0;
            out_rd_addr <= '0;
            out_rd_we   <= 1'b0;
            out_is_load <= 1'b0;
            stall_count <= '0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_rd_we   <= 1'b0;
            out_is_load <= 1'b0;
        end else if (accept_c) begin
            if (in_valid && !hazard_c) begin
                out_valid   <= 1'b1;
                out_opcode  <= in_opcode;
                out_op1     <= op1_c;
                out_op2     <= op2_c;
                out_imm     <= in_imm;
                out_rd_addr <= in_rd_addr;
                out_rd_we   <= in_rd_we;
                out_is_load <= in_is_load;
            end else begin
                out_valid   <= 1'b0;
                out_rd_we   <= 1'b0;
                out_is_load <= 1'b0;
                if (hazard_c && stall_count != STALL_MAX)
                    stall_count <= stall_count + SCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a rule-level reference model checked
// every cycle plus literal expectations for each scenario.
module tb_id_ex_stage;

    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [4:0]   in_opcode;
    logic [N-1:0] in_imm;
    logic [2:0]   in_rd_addr;
    logic         in_rd_we, in_is_load;
    logic [2:0]   in_rs1_addr, in_rs2_addr;
    logic         in_use_rs1, in_use_rs2;
    logic [N-1:0] rf_read_data1, rf_read_data2;
    logic         ex_fwd_we, mem_fwd_we, wb_fwd_we;
    logic [2:0]   ex_fwd_addr, mem_fwd_addr, wb_fwd_addr;
    logic [N-1:0] ex_fwd_data, mem_fwd_data, wb_fwd_data;
    logic         flush;
    logic         out_valid, out_ready;
    logic [4:0]   out_opcode;
    logic [N-1:0] out_op1, out_op2, out_imm;
    logic [2:0]   out_rd_addr;
    logic         out_rd_we, out_is_load;
    logic [15:0]  stall_count;

    logic [N-1:0] rf [8];
    assign rf_read_data1 = rf[in_rs1_addr];
    assign rf_read_data2 = rf[in_rs2_addr];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_imm(in_imm), .in_rd_addr(in_rd_addr),
        .in_rd_we(in_rd_we), .in_is_load(in_is_load),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .ex_fwd_we(ex_fwd_we), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_op1(out_op1), .out_op2(out_op2),
        .out_imm(out_imm), .out_rd_addr(out_rd_addr),
        .out_rd_we(out_rd_we), .out_is_load(out_is_load),
        .stall_count(stall_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic         m_valid, m_we, m_ld;
    logic [4:0]   m_op;
    logic [N-1:0] m_op1, m_op2, m_imm;
    logic [2:0]   m_rd;
    logic [15:0]  m_stall;

    function automatic logic [N-1:0] model_operand(input logic use_rs, input logic [2:0] a);
        logic         we [3];
        logic [2:0]   ad [3];
        logic [N-1:0] dt [3];
        we[0] = ex_fwd_we;  ad[0] = ex_fwd_addr;  dt[0] = ex_fwd_data;
        we[1] = mem_fwd_we; ad[1] = mem_fwd_addr; dt[1] = mem_fwd_data;
        we[2] = wb_fwd_we;  ad[2] = wb_fwd_addr;  dt[2] = wb_fwd_data;
        if (use_rs)
            for (int k = 0; k < 3; k++)
                if (we[k] && ad[k] == a) return dt[k];
        return rf[a];
    endfunction

    function automatic logic model_stall();
        if (!(in_valid && m_valid && m_ld && m_we)) return 1'b0;
        return (in_use_rs1 && in_rs1_addr == m_rd) || (in_use_rs2 && in_rs2_addr == m_rd);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid = 0; m_we = 0; m_ld = 0; m_op = 0;
            m_op1 = 0; m_op2 = 0; m_imm = 0; m_rd = 0; m_stall = 0;
        end else if (flush) begin
            m_valid = 0; m_we = 0; m_ld = 0;
        end else if (!m_valid || out_ready) begin
            if (model_stall()) begin
                m_valid = 0; m_we = 0; m_ld = 0;
                if (m_stall < 16'hFFFF) m_stall = m_stall + 16'd1;
            end else if (in_valid) begin
                m_valid = 1;
                m_op  = in_opcode;
                m_op1 = model_operand(in_use_rs1, in_rs1_addr);
                m_op2 = model_operand(in_use_rs2, in_rs2_addr);
                m_imm = in_imm;
                m_rd  = in_rd_addr;
                m_we  = in_rd_we;
                m_ld  = in_is_load;
            end else begin
                m_valid = 0; m_we = 0; m_ld = 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready", 32'(in_ready),
                32'(flush || ((!m_valid || out_ready) && !model_stall())));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("stall_count", 32'(stall_count), 32'(m_stall));
            if (m_valid) begin
                chk("out_opcode", 32'(out_opcode), 32'(m_op));
                chk("out_op1", 32'(out_op1), 32'(m_op1));
                chk("out_op2", 32'(out_op2), 32'(m_op2));
                chk("out_imm", 32'(out_imm), 32'(m_imm));
                chk("out_rd_addr", 32'(out_rd_addr), 32'(m_rd));
            end
            chk("out_rd_we", 32'(out_rd_we), 32'(m_we));
            chk("out_is_load", 32'(out_is_load), 32'(m_ld));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [4:0] op, input logic [2:0] rd, input logic we,
                             input logic ld, input logic [2:0] rs1, input logic u1,
                             input logic [N-1:0] imm);
        in_valid = 1; in_opcode = op; in_rd_addr = rd; in_rd_we = we; in_is_load = ld;
        in_rs1_addr = rs1; in_use_rs1 = u1; in_rs2_addr = 3'd6; in_use_rs2 = 0;
        in_imm = imm;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) rf[k] = N'(k) << 12;
        rst = 0; out_ready = 1; flush = 0;
        in_valid = 0; in_opcode = 0; in_imm = 0; in_rd_addr = 0; in_rd_we = 0;
        in_is_load = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_use_rs1 = 0; in_use_rs2 = 0;
        ex_fwd_we = 0; ex_fwd_addr = 0; ex_fwd_data = 0;
        mem_fwd_we = 0; mem_fwd_addr = 0; mem_fwd_data = 0;
        wb_fwd_we = 0; wb_fwd_addr = 0; wb_fwd_data = 0;
        #3;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_stall", 32'(stall_count), 32'd0);
        chk("reset_opcode", 32'(out_opcode), 32'd0);
        tick(); tick();
        rst = 1;

        // back-to-back ALU instructions
        for (int i = 0; i < 4; i++) begin
            set_instr(5'(i + 1), 3'(i + 1), 1, 0, 3'd7, 1, N'(i * 16 + 5));
            tick();
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_opcode", 32'(out_opcode), 32'(i + 1));
            chk("b2b_imm", 32'(out_imm), 32'(i * 16 + 5));
        end
        chk("b2b_op1", 32'(out_op1), 32'h7000);
        in_valid = 0;
        tick();
        chk("b2b_drain", 32'(out_valid), 32'd0);
        chk("b2b_stall", 32'(stall_count), 32'd0);

        // load-use: one bubble then issue
        set_instr(5'd5, 3'd3, 1, 1, 3'd0, 0, 16'h0);
        tick();
        set_instr(5'd6, 3'd4, 1, 0, 3'd3, 1, 16'h0);
        #1;
        chk("lu_in_ready_stall", 32'(in_ready), 32'd0);
        tick();
        chk("lu_bubble", 32'(out_valid), 32'd0);
        chk("lu_stall1", 32'(stall_count), 32'd1);
        #1;
        chk("lu_in_ready_go", 32'(in_ready), 32'd1);
        tick();
        chk("lu_issue", 32'(out_opcode), 32'd6);
        chk("lu_op1", 32'(out_op1), 32'h3000);
        in_valid = 0;
        tick();

        // forwarding priority
        rf[2] = 16'h4444;
        set_instr(5'd7, 3'd1, 1, 0, 3'd2, 1, 16'h0);
        in_rs2_addr = 3'd2;
        ex_fwd_we = 1;  ex_fwd_addr = 2;  ex_fwd_data = 16'h1111;
        mem_fwd_we = 1; mem_fwd_addr = 2; mem_fwd_data = 16'h2222;
        wb_fwd_we = 1;  wb_fwd_addr = 2;  wb_fwd_data = 16'h3333;
        tick();
        chk("fwd_ex", 32'(out_op1), 32'h1111);
        chk("fwd_unused_op2", 32'(out_op2), 32'h4444);
        ex_fwd_we = 0;
        tick();
        chk("fwd_mem", 32'(out_op1), 32'h2222);
        mem_fwd_we = 0;
        tick();
        chk("fwd_wb", 32'(out_op1), 32'h3333);
        wb_fwd_we = 0;
        in_rs1_addr = 0; ex_fwd_we = 1; ex_fwd_addr = 0; ex_fwd_data = 16'hABCD;
        tick();
        chk("fwd_addr0", 32'(out_op1), 32'hABCD);
        ex_fwd_we = 0;
        in_valid = 0;
        tick();

        // backpressure
        set_instr(5'd8, 3'd1, 1, 0, 3'd0, 0, 16'h000A);
        tick();
        set_instr(5'd9, 3'd2, 1, 0, 3'd0, 0, 16'h000B);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_op", 32'(out_opcode), 32'd8);
            chk("bp_hold_imm", 32'(out_imm), 32'h000A);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_next_op", 32'(out_opcode), 32'd9);
        in_valid = 0;
        tick();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // flush during hazard
        set_instr(5'd5, 3'd3, 1, 1, 3'd0, 0, 16'h0);
        tick();
        set_instr(5'd6, 3'd4, 1, 0, 3'd3, 1, 16'h0);
        flush = 1;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_stall", 32'(stall_count), 32'd1);
        flush = 0; in_valid = 0;
        tick();

        // asynchronous reset while a load-use stall is pending
        set_instr(5'd5, 3'd3, 1, 1, 3'd0, 0, 16'h0);
        tick();
        set_instr(5'd6, 3'd4, 1, 0, 3'd3, 1, 16'h0);
        #1;
        rst = 0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_stall", 32'(stall_count), 32'd0);
        tick();
        rst = 1;
        tick();
        chk("rst_first_valid", 32'(out_valid), 32'd1);
        chk("rst_first_op", 32'(out_opcode), 32'd6);
        chk("rst_first_stall", 32'(stall_count), 32'd0);
        in_valid = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
